uart_event_parser: RTL

Byte-to-event front end between the UART receiver and the DVS gesture accelerator. It parses 5-byte DVS event packets, diverts single-byte command codes, range-checks coordinates and timestamps each event. Accepted events are buffered in a small first-word-fall-through FIFO that drives the accelerator's valid/ready event port. With it, events arriving while the accelerator is busy are held instead of silently lost.

---
 rtl/uart_event_parser.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_event_parser.sv
// uart_event_parser: turns a UART byte stream into DVS events.
// Five-byte packets (X_HI, X_LO, Y_HI, Y_LO, POL) are range-checked,
// timestamped and pushed into a first-word-fall-through FIFO that drives
// a valid/ready event port. Bytes 0xFC-0xFF at a packet boundary are
// diverted as one-cycle command strobes.
// Optional feature: define EVT_PARSER_TIMEOUT_EN to abandon a partial
// packet after TIMEOUT_CYCLES idle cycles (sync_lost pulses once).
//
// Event port handshake: event_valid is high while the FIFO holds an entry
// and the head entry sits on event_x/y/polarity/ts; an entry is consumed on
// every rising clock edge where event_valid && event_ready, and the next
// entry (if any) is presented in the following cycle.
module uart_event_parser #(
    parameter int SENSOR_RES     = 320,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2080
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          event_valid,
    output logic [8:0]                    event_x,
    output logic [8:0]                    event_y,
    output logic                          event_polarity,
    output logic [15:0]                   event_ts,
    input  logic                          event_ready,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_code,
    output logic                          sync_lost,
    output logic [7:0]                    drop_count,
    output logic [7:0]                    range_err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
    localparam logic [9:0]  RES_L   = SENSOR_RES[9:0];

    typedef enum logic [2:0] {
        S_X_HI,
        S_X_LO,
        S_Y_HI,
        S_Y_LO,
        S_POL
    } state_t;

    state_t        state;
    logic [8:0]    x_q;
    logic [8:0]    y_q;
    logic [15:0]   ts_counter;
    logic [34:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          timeout_hit;

    // Completion decisions are made on the POL byte using the already captured X/Y.
    logic pol_byte;
    logic in_range;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic range_err;

    assign pol_byte  = rx_valid && (state == S_POL);
    assign in_range  = ({1'b0, x_q} < RES_L) && ({1'b0, y_q} < RES_L);
    assign full      = (level == DEPTH_L);
    assign pop       = event_valid && event_ready;
    assign push      = pol_byte && in_range && (!full || pop);
    assign drop      = pol_byte && in_range && full && !pop;
    assign range_err = pol_byte && !in_range;

    assign event_valid = (level != '0);
    assign fifo_level  = level;
    assign {event_x, event_y, event_polarity, event_ts} = mem[rd_ptr];

    // Parser FSM: field capture and command detection with registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_X_HI;
            x_q       <= '0;
            y_q       <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 2'd0;
        end else begin
            cmd_valid <= 1'b0;
            if (rx_valid) begin
                case (state)
                    S_X_HI: begin
                        if (rx_data >= 8'hFC) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= rx_data[1:0];
                        end else begin
                            x_q[8] <= rx_data[0];
                            state  <= S_X_LO;
                        end
                    end
                    S_X_LO: begin
                        x_q[7:0] <= rx_data;
                        state    <= S_Y_HI;
                    end
                    S_Y_HI: begin
                        y_q[8] <= rx_data[0];
                        state  <= S_Y_LO;
                    end
                    S_Y_LO: begin
                        y_q[7:0] <= rx_data;
                        state    <= S_POL;
                    end
                    S_POL:   state <= S_X_HI;
                    default: state <= S_X_HI;
                endcase
            end else if (timeout_hit) begin
                state <= S_X_HI;
            end
        end
    end

    // Event FIFO, timestamp counter and saturating discard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            ts_counter      <= '0;
            drop_count      <= '0;
            range_err_count <= '0;
        end else begin
            ts_counter <= ts_counter + 16'd1;
            if (push) begin
                mem[wr_ptr] <= {x_q, y_q, rx_data[0], ts_counter};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (range_err && (range_err_count != 8'hFF)) begin
                range_err_count <= range_err_count + 8'd1;
            end
        end
    end

`ifdef EVT_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;

    // A received byte wins over an expiring timeout in the same cycle.
    assign timeout_hit = (state != S_X_HI) && !rx_valid && (idle_cnt == TO_LAST);

    // Idle counter: cleared by any byte, held at zero while waiting for a packet start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_valid || (state == S_X_HI) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // One-cycle sync_lost pulse when a partial packet is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_lost <= 1'b0;
        end else begin
            sync_lost <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign sync_lost   = 1'b0;
`endif

endmodule
